// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mem_pkg;

  // Bit positions inside sign_mask = {unsigned, size_onehot[2:0]}
  localparam int SM_UNS_BIT = 3;
  localparam int SM_SIZE_LSB = 0;

  // One-hot access size encodings
  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  // Default byte address of the MMIO LED register
  localparam logic [31:0] MMIO_BASE_DEF = 32'h0000_2000;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  // True when the size field names exactly one legal access width
  function automatic logic size_is_legal(input logic [2:0] size);
    return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a 32-bit memory word.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and half-word lanes out of the word
  always_comb begin
    byte_lane = word_i[7:0];
    case (offset_i)
      2'd0: byte_lane = word_i[7:0];
      2'd1: byte_lane = word_i[15:8];
      2'd2: byte_lane = word_i[23:16];
      2'd3: byte_lane = word_i[31:24];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extend the selected lane to 32 bits according to size and signedness
  always_comb begin
    result_o = word_i;
    if (size_i == SIZE_B) begin
      result_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
    end else if (size_i == SIZE_H) begin
      result_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access stage: CPU load/store to word SRAM plus one MMIO LED register.
// Latency: stores and MMIO accesses complete with no stall; SRAM loads take one stall cycle.
// Backpressure: stall_o holds the CPU while an SRAM read is in flight.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(MMIO_BASE_DEF),
  localparam int               IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              memwrite_i,
  input  logic              memread_i,
  input  logic [3:0]        sign_mask_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic [7:0]        led_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  state_t      state_q, state_d;
  logic [1:0]  req_off_q;
  logic [2:0]  req_size_q;
  logic        req_uns_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic [7:0]  led_q;

  logic [2:0]  size;
  logic        is_misaligned;
  logic        is_mmio;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] ext_data;
  logic        set_misalign;
  logic        led_we;
  logic        latch_req;
  logic        hold_we;

  assign size    = sign_mask_i[SM_SIZE_LSB +: 3];
  assign is_mmio = (addr_i >= MMIO_BASE);

  // Alignment check: illegal sizes are treated as misaligned too
  always_comb begin
    is_misaligned = 1'b0;
    if (!size_is_legal(size)) begin
      is_misaligned = 1'b1;
    end else if (size == SIZE_H && addr_i[0]) begin
      is_misaligned = 1'b1;
    end else if (size == SIZE_W && addr_i[1:0] != 2'b00) begin
      is_misaligned = 1'b1;
    end
  end

  // Byte enables and lane replication for stores
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = wdata_i;
    if (size == SIZE_B) begin
      store_be    = 4'b0001 << addr_i[1:0];
      store_wdata = {4{wdata_i[7:0]}};
    end else if (size == SIZE_H) begin
      store_be    = 4'b0011 << addr_i[1:0];
      store_wdata = {2{wdata_i[15:0]}};
    end
  end

  // Extract and extend the returning SRAM word using the latched request
  load_extend u_load_extend (
    .offset_i   (req_off_q),
    .size_i     (req_size_q),
    .unsigned_i (req_uns_q),
    .word_i     (sram_rdata_i),
    .result_o   (ext_data)
  );

  assign sram_addr_o  = addr_i[2 +: IDX_W];
  assign sram_wdata_o = store_wdata;
  assign misalign_o   = misalign_q;
  assign led_o        = led_q;

  // Next-state and output decode; stores win over a simultaneous load
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 4'b0000;
    rdata_o      = rdata_q;
    set_misalign = 1'b0;
    led_we       = 1'b0;
    latch_req    = 1'b0;
    hold_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (memwrite_i) begin
          if (memread_i || is_misaligned) begin
            set_misalign = 1'b1;
          end
          if (!is_misaligned) begin
            if (is_mmio) begin
              led_we = 1'b1;
            end else begin
              sram_en_o = 1'b1;
              sram_we_o = 1'b1;
              sram_be_o = store_be;
            end
          end
        end else if (memread_i) begin
          if (is_misaligned) begin
            set_misalign = 1'b1;
            rdata_o      = 32'h0;
          end else if (is_mmio) begin
            rdata_o = {24'h0, led_q};
          end else begin
            sram_en_o = 1'b1;
            stall_o   = 1'b1;
            latch_req = 1'b1;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Stores are ignored here: the CPU is frozen by the previous stall
        rdata_o = ext_data;
        hold_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch, held load data, sticky flag and LED register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      req_off_q  <= 2'b00;
      req_size_q <= SIZE_W;
      req_uns_q  <= 1'b0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
      led_q      <= 8'h00;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_off_q  <= addr_i[1:0];
        req_size_q <= size;
        req_uns_q  <= sign_mask_i[SM_UNS_BIT];
      end
      if (hold_we) begin
        rdata_q <= ext_data;
      end
      if (set_misalign) begin
        misalign_q <= 1'b1;
      end
      if (led_we) begin
        led_q <= wdata_i[7:0];
      end
    end
  end

endmodule
